pressure_threshold_detector: RTL and testbench
==============================================

Name: pressure_threshold_detector

Overview:
- Upstream conditioning stage for the pressure-sensor alarm path. Consumes raw ADC pressure samples and smooths them with a 2^AVG_LOG2-point moving average.
- Applies high/low hysteresis thresholds with a persistence (consecutive-sample) filter.
- Produces a registered alarm level that drives the data input of the downstream alarm-latch flip-flop, plus one-cycle rise/fall event pulses.

Parameters:
- DATA_W, 12, ADC sample width in bits.
- AVG_LOG2, 2, log2 of moving-average window; window = 4 samples. Legal range 0..4.
- HIGH_TH, 3000, averaged value >= HIGH_TH counts as over-pressure. Must be > LOW_TH.
- LOW_TH, 2500, averaged value <= LOW_TH counts as recovered.
- PERSIST, 4, consecutive qualifying averages needed to change alarm state. Legal range 1..15.

Ports:
- clk, input, 1, system clock, rising-edge.
- reset, input, 1, asynchronous active-high reset.
- sample_valid, input, 1, sample_data is valid this cycle.
- sample_data, input, DATA_W, unsigned raw pressure sample.
- avg_valid, output, 1, one-cycle strobe: avg_data updated.
- avg_data, output, DATA_W, unsigned moving-average value.
- alarm, output, 1, registered over-pressure level (feeds downstream flip-flop d).
- alarm_rise, output, 1, one-cycle pulse on alarm 0->1.
- alarm_fall, output, 1, one-cycle pulse on alarm 1->0.

Behaviour:
- Reset (async, active-high) clears:
  - all outputs to 0, FSM to IDLE_LOW, persistence counter to 0;
  - window sample registers, running sum and fill counter to 0.
- Everything is registered on posedge clk. Cycles without sample_valid hold all state and clear avg_valid and the pulses.
- Moving average:
  - Window shift register of 2^AVG_LOG2 samples; running sum width DATA_W+AVG_LOG2 (no overflow possible).
  - On sample_valid: sum <= sum + sample_data - oldest; shift window.
  - avg_data = new sum >> AVG_LOG2 (truncate, no rounding).
  - Fill: avg_valid stays 0 until 2^AVG_LOG2 samples have been accepted since reset. The first avg_valid comes with the 4th sample (default).
  - Thereafter avg_valid pulses 1 cycle after each sample_valid; latency 1 clk.
  - AVG_LOG2=0: avg_data = sample_data, latency 1.
- Hysteresis FSM (advances only on the cycle avg_valid=1, evaluated on the registered avg_data):
  - IDLE_LOW (alarm=0):
    - avg >= HIGH_TH: cnt=1 and go to PEND_HIGH.
    - If PERSIST=1, go directly to ALARM_HIGH.
  - PEND_HIGH:
    - avg >= HIGH_TH: cnt++. When cnt reaches PERSIST, go to ALARM_HIGH, cnt=0.
    - avg < HIGH_TH: go to IDLE_LOW, cnt=0.
  - ALARM_HIGH (alarm=1):
    - avg <= LOW_TH: cnt=1 and go to PEND_LOW (ALARM_HIGH->IDLE_LOW directly if PERSIST=1).
    - LOW_TH < avg < HIGH_TH: stay.
  - PEND_LOW (alarm stays 1):
    - avg <= LOW_TH: cnt++. At PERSIST, go to IDLE_LOW, cnt=0.
    - avg > LOW_TH: return to ALARM_HIGH, cnt=0.
- alarm is a registered copy of (state in ALARM_HIGH/PEND_LOW).
  - It changes the cycle after the qualifying avg_valid, i.e. 2 clk after the final qualifying sample_valid.
- alarm_rise/alarm_fall are asserted for exactly that one cycle, coincident with the alarm edge; never both at once.
- Values exactly at a threshold qualify (>= HIGH_TH, <= LOW_TH).
- Reset mid-pending or mid-alarm: alarm drops to 0 immediately (async) with no alarm_fall pulse, and the window must refill.
- Back-to-back sample_valid every cycle is supported at full rate.

Test Plan:
- Reset/fill: assert reset, then feed 3 samples of 4000 -> avg_valid=0, alarm=0. The 4th sample gives avg_valid=1 next cycle with avg_data=4000.
- Averaging/truncation: feed 1,2,3,4 -> avg_data=2 (10>>2). Then feed 8 -> avg_data=4 (17>>2).
- Alarm assertion: prefill 4x1000, then 7 samples of 3200 every cycle.
  - First avg >= 3000 is 3200 after the 4th 3200 sample; alarm rises after PERSIST=4 qualifying averages.
  - Check alarm_rise is a single-cycle pulse 2 clk after the 7th sample_valid.
- Persistence break: in PEND_HIGH with cnt=3, inject averages dropping to 2900 -> FSM returns to IDLE_LOW, alarm stays 0, no alarm_rise.
- Hysteresis/release: with alarm=1, feed steady 2700 (between thresholds) for 20 samples -> alarm stays 1.
  - Then feed 2400 until 4 averages <= 2500 -> alarm 1->0 with one alarm_fall pulse.
- Reset mid-alarm: with alarm=1, pulse reset asynchronously between clock edges -> alarm=0 immediately, no alarm_fall. Next avg_valid appears only after 4 new samples.

Source files
------------

// File: rtl/pressure_threshold_detector_if.sv
// Sample-in / average-and-alarm-out bundle for the pressure conditioning stage.
// The master drives raw ADC samples; the slave is the detector.
interface pressure_threshold_detector_if #(
    parameter int DATA_W = 12
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_data;
    logic              alarm;
    logic              alarm_rise;
    logic              alarm_fall;

    modport master (
        output sample_valid, sample_data,
        input  avg_valid, avg_data, alarm, alarm_rise, alarm_fall
    );

    modport slave (
        input  sample_valid, sample_data,
        output avg_valid, avg_data, alarm, alarm_rise, alarm_fall
    );
endinterface

// File: rtl/pressure_threshold_detector.sv
// Moving-average smoother followed by a hysteresis + persistence alarm FSM.
// The alarm level is registered and feeds the downstream alarm-latch flop.
module pressure_threshold_detector #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int HIGH_TH  = 3000,
    parameter int LOW_TH   = 2500,
    parameter int PERSIST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    pressure_threshold_detector_if.slave  bus
);
    localparam int WIN    = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    localparam logic [1:0] IDLE_LOW   = 2'd0;
    localparam logic [1:0] PEND_HIGH  = 2'd1;
    localparam logic [1:0] ALARM_HIGH = 2'd2;
    localparam logic [1:0] PEND_LOW   = 2'd3;

    localparam logic [DATA_W-1:0] HIGH_V  = DATA_W'(HIGH_TH);
    localparam logic [DATA_W-1:0] LOW_V   = DATA_W'(LOW_TH);
    localparam logic [3:0]        PERS_V  = 4'(PERSIST);
    localparam logic [FILL_W-1:0] WIN_V   = FILL_W'(WIN);
    localparam logic [FILL_W-1:0] WIN_M1  = FILL_W'(WIN - 1);

    // win_q[0] is the newest sample, win_q[WIN-1] the oldest
    logic [WIN-1:0][DATA_W-1:0] win_q, win_d;
    logic [SUM_W-1:0]           sum_q, sum_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic [DATA_W-1:0]          avg_q, avg_d;
    logic                       avg_valid_q, avg_valid_d;
    logic [1:0]                 state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       alarm_q, alarm_d;
    logic                       rise_q, fall_q;

    always_comb begin
        win_d[0] = bus.sample_data;
        for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
        sum_d       = sum_q + SUM_W'(bus.sample_data) - SUM_W'(win_q[WIN-1]);
        avg_d       = sum_d[SUM_W-1:AVG_LOG2];
        fill_d      = (fill_q == WIN_V) ? fill_q : fill_q + 1'b1;
        avg_valid_d = bus.sample_valid && (fill_q >= WIN_M1);
    end

    // FSM only moves on the cycle a fresh average is presented
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (avg_valid_q) begin
            case (state_q)
                IDLE_LOW: if (avg_q >= HIGH_V) begin
                    if (PERSIST == 1) begin
                        state_d = ALARM_HIGH;
                        cnt_d   = '0;
                    end else begin
                        state_d = PEND_HIGH;
                        cnt_d   = 4'd1;
                    end
                end
                PEND_HIGH: if (avg_q >= HIGH_V) begin
                    if (cnt_q + 4'd1 == PERS_V) begin
                        state_d = ALARM_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
                ALARM_HIGH: if (avg_q <= LOW_V) begin
                    if (PERSIST == 1) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = PEND_LOW;
                        cnt_d   = 4'd1;
                    end
                end
                default: if (avg_q <= LOW_V) begin
                    if (cnt_q + 4'd1 == PERS_V) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ALARM_HIGH;
                    cnt_d   = '0;
                end
            endcase
        end
        alarm_d = (state_d == ALARM_HIGH) || (state_d == PEND_LOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            state_q     <= IDLE_LOW;
            cnt_q       <= '0;
            alarm_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            avg_valid_q <= avg_valid_d;
            if (bus.sample_valid) begin
                win_q  <= win_d;
                sum_q  <= sum_d;
                fill_q <= fill_d;
            end
            if (avg_valid_d) avg_q <= avg_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            rise_q  <= alarm_d & ~alarm_q;
            fall_q  <= ~alarm_d & alarm_q;
        end
    end

    assign bus.avg_valid  = avg_valid_q;
    assign bus.avg_data   = avg_q;
    assign bus.alarm      = alarm_q;
    assign bus.alarm_rise = rise_q;
    assign bus.alarm_fall = fall_q;
endmodule

// File: tb/tb_pressure_threshold_detector.sv
// Directed-vector bench for pressure_threshold_detector (default parameters).
module tb_pressure_threshold_detector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    pressure_threshold_detector_if #(.DATA_W(12)) bus ();

    pressure_threshold_detector #(
        .DATA_W(12), .AVG_LOG2(2), .HIGH_TH(3000), .LOW_TH(2500), .PERSIST(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one sample for exactly one edge, then leave the bus idle
    task automatic feed(input logic [11:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic idle();
        bus.sample_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [11:0] a,
                           input logic al, input logic r, input logic f);
        chk({tag, ".avg_valid"}, 32'(bus.avg_valid), 32'(v));
        if (v) chk({tag, ".avg_data"}, 32'(bus.avg_data), 32'(a));
        chk({tag, ".alarm"}, 32'(bus.alarm), 32'(al));
        chk({tag, ".rise"}, 32'(bus.alarm_rise), 32'(r));
        chk({tag, ".fall"}, 32'(bus.alarm_fall), 32'(f));
    endtask

    // back-to-back samples with the expected average after each one
    task automatic burst(input string tag, input logic [11:0] d, input int n,
                         input logic al);
        logic [11:0] exp_avg [0:6];
        exp_avg = '{1550, 2100, 2650, 3200, 3200, 3200, 3200};
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_data  = d;
            tick();
            chk_out($sformatf("%s[%0d]", tag, i), 1'b1, exp_avg[i], al, 1'b0, 1'b0);
        end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;

        // reset state
        tick();
        tick();
        chk("rst.avg_data", 32'(bus.avg_data), 0);
        chk_out("rst", 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // fill: first average only after the fourth sample
        for (int i = 0; i < 3; i++) begin
            feed(12'd4000);
            chk_out($sformatf("fill%0d", i), 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        end
        feed(12'd4000);
        chk_out("fill3", 1'b1, 12'd4000, 1'b0, 1'b0, 1'b0);
        idle();
        chk("fill.strobe_drop", 32'(bus.avg_valid), 0);

        // averaging with truncation
        do_reset();
        feed(12'd1); feed(12'd2); feed(12'd3);
        chk("avg.prefill", 32'(bus.avg_valid), 0);
        feed(12'd4);
        chk_out("avg.10", 1'b1, 12'd2, 1'b0, 1'b0, 1'b0);
        feed(12'd8);
        chk_out("avg.17", 1'b1, 12'd4, 1'b0, 1'b0, 1'b0);
        idle();
        chk("avg.hold", 32'(bus.avg_data), 4);
        chk("avg.strobe", 32'(bus.avg_valid), 0);

        // alarm assertion after four qualifying averages
        do_reset();
        for (int i = 0; i < 4; i++) feed(12'd1000);
        chk_out("pre1000", 1'b1, 12'd1000, 1'b0, 1'b0, 1'b0);
        burst("rise", 12'd3200, 7, 1'b0);
        idle();
        chk_out("rise.edge", 1'b0, 12'd0, 1'b1, 1'b1, 1'b0);
        idle();
        chk_out("rise.after", 1'b0, 12'd0, 1'b1, 1'b0, 1'b0);

        // between thresholds the alarm holds
        for (int i = 0; i < 20; i++) begin
            feed(12'd2700);
            chk($sformatf("hyst.alarm[%0d]", i), 32'(bus.alarm), 1);
            chk($sformatf("hyst.fall[%0d]", i), 32'(bus.alarm_fall), 0);
        end
        chk("hyst.avg", 32'(bus.avg_data), 2700);

        // release: averages 2625,2550,2475,2400,2400,2400
        for (int i = 0; i < 6; i++) begin
            feed(12'd2400);
            chk($sformatf("rel.alarm[%0d]", i), 32'(bus.alarm), 1);
        end
        chk("rel.avg", 32'(bus.avg_data), 2400);
        idle();
        chk_out("fall.edge", 1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
        idle();
        chk_out("fall.after", 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);

        // persistence break: 2600,2800,3000,3200,3200 then 2900
        feed(12'd3200); feed(12'd3200);
        feed(12'd3200);
        chk("brk.at_high", 32'(bus.avg_data), 3000);
        feed(12'd3200); feed(12'd3200);
        feed(12'd2000);
        chk("brk.avg", 32'(bus.avg_data), 2900);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_out($sformatf("brk.idle%0d", i), 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        end

        // reset mid-alarm
        do_reset();
        for (int i = 0; i < 7; i++) feed(12'd3200);
        idle();
        chk("mid.alarm_up", 32'(bus.alarm), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid.async_alarm", 32'(bus.alarm), 0);
        chk("mid.async_fall", 32'(bus.alarm_fall), 0);
        #1 reset = 1'b0;
        idle();
        chk_out("mid.post", 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            feed(12'd3200);
            chk_out($sformatf("refill%0d", i), 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        end
        feed(12'd3200);
        chk_out("refill3", 1'b1, 12'd3200, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
